dmem_port_arbiter: RTL and testbench

//  Shares the single-port pipelined data memory (Pipedmem: clka/wea/addra/dina/douta, 1-cycle read) between
//  the CPU MEM stage and a debug/LCD burst-read engine. CPU has priority; a starvation counter guarantees debug

---
 rtl/dmem_port_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Single-port data memory arbiter between the CPU MEM stage and a debug
//   burst-read engine. CPU has priority; a starvation counter forces one
//   debug slot after STARVE_MAX consecutive CPU wins while debug is pending.
//   Memory is assumed to have a 1-cycle registered read (mem_dout valid the
//   cycle after the address is presented).
//   Optional feature macro: DMEM_ARB_DBG_WRITE_EN adds a single-word debug
//   write port (dbg_wr_req/dbg_wr_addr/dbg_wr_data/dbg_wr_ack).
module dmem_port_arbiter #(
  parameter int LEN_W      = 8,
  parameter int STARVE_MAX = 3,
  parameter int ADDR_STEP  = 1
) (
  input  logic             clka,
  input  logic             rst_n,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic             cpu_stall,
  output logic             cpu_rvalid,
  output logic [31:0]      cpu_rdata,
  input  logic             dbg_start,
  input  logic [31:0]      dbg_base,
  input  logic [LEN_W-1:0] dbg_len,
  output logic             dbg_busy,
  output logic             dbg_rvalid,
  output logic [31:0]      dbg_rdata,
  output logic [LEN_W-1:0] dbg_idx,
  output logic             dbg_done,
`ifdef DMEM_ARB_DBG_WRITE_EN
  input  logic             dbg_wr_req,
  input  logic [31:0]      dbg_wr_addr,
  input  logic [31:0]      dbg_wr_data,
  output logic             dbg_wr_ack,
`endif
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_din,
  input  logic [31:0]      mem_dout
);

  localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [31:0] STEP       = 32'(ADDR_STEP);

  typedef enum logic [1:0] {D_IDLE, D_RUN, D_DRAIN, D_DONE} dstate_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DBG} owner_t;

  dstate_t          r_state;
  dstate_t          w_state_nxt;
  owner_t           r_rd_owner;
  logic [3:0]       r_starve;
  logic [31:0]      r_addr;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_issue_idx;
  logic [LEN_W-1:0] r_ret_idx;
  logic [31:0]      r_cpu_hold;
  logic [31:0]      r_dbg_hold;

  logic             w_rd_pend;
  logic             w_wr_pend;
  logic             w_dbg_pend;
  logic             w_dbg_grant;
  logic             w_dbg_rd_grant;
  logic             w_dbg_wr_grant;
  logic             w_cpu_grant;
  logic             w_last_issue;
  logic [31:0]      w_wr_addr;
  logic [31:0]      w_wr_data;

`ifdef DMEM_ARB_DBG_WRITE_EN
  assign w_wr_pend  = dbg_wr_req;
  assign w_wr_addr  = dbg_wr_addr;
  assign w_wr_data  = dbg_wr_data;
  assign dbg_wr_ack = w_dbg_wr_grant;
`else
  assign w_wr_pend  = 1'b0;
  assign w_wr_addr  = '0;
  assign w_wr_data  = '0;
`endif

  // Grant: debug wins when pending and CPU idle or starved; burst read before debug write.
  // rst_n gates the grants so memory pins and stall stay quiet during reset.
  assign w_rd_pend      = (r_state == D_RUN);
  assign w_dbg_pend     = w_rd_pend | w_wr_pend;
  assign w_dbg_grant    = rst_n & w_dbg_pend & (~cpu_req | (r_starve == STARVE_LIM));
  assign w_dbg_rd_grant = w_dbg_grant & w_rd_pend;
  assign w_dbg_wr_grant = w_dbg_grant & ~w_rd_pend;
  assign w_cpu_grant    = rst_n & cpu_req & ~w_dbg_grant;
  assign cpu_stall      = rst_n & cpu_req & ~w_cpu_grant;
  assign w_last_issue   = (r_issue_idx == (r_len - LEN_W'(1)));

  // Memory pin mux driven from the current winner; idle drives zeros.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (w_dbg_rd_grant) begin
      mem_addr = r_addr;
    end else if (w_dbg_wr_grant) begin
      mem_we   = 1'b1;
      mem_addr = w_wr_addr;
      mem_din  = w_wr_data;
    end else if (w_cpu_grant) begin
      mem_we   = cpu_we;
      mem_addr = cpu_addr;
      mem_din  = cpu_wdata;
    end
  end

  // Starvation counter: counts CPU wins while debug waits, saturating at the limit.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (!w_dbg_pend || w_dbg_grant) begin
      r_starve <= '0;
    end else if (w_cpu_grant && (r_starve < STARVE_LIM)) begin
      r_starve <= r_starve + 4'd1;
    end
  end

  // Burst FSM state register.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= D_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Burst FSM next state and status outputs; the final return is seen in D_DRAIN.
  always_comb begin
    w_state_nxt = r_state;
    dbg_busy    = 1'b1;
    dbg_done    = 1'b0;
    unique case (r_state)
      D_IDLE: begin
        dbg_busy = 1'b0;
        if (dbg_start) begin
          w_state_nxt = (dbg_len == '0) ? D_DONE : D_RUN;
        end
      end
      D_RUN: begin
        if (w_dbg_rd_grant && w_last_issue) begin
          w_state_nxt = D_DRAIN;
        end
      end
      D_DRAIN: begin
        if (r_rd_owner == OWN_DBG) begin
          dbg_done    = 1'b1;
          w_state_nxt = D_IDLE;
        end
      end
      D_DONE: begin
        dbg_done    = 1'b1;
        w_state_nxt = D_IDLE;
      end
      default: w_state_nxt = D_IDLE;
    endcase
  end

  // Burst address/index bookkeeping; base and length latched only on an accepted start.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_len       <= '0;
      r_issue_idx <= '0;
    end else if ((r_state == D_IDLE) && dbg_start) begin
      r_addr      <= dbg_base;
      r_len       <= dbg_len;
      r_issue_idx <= '0;
    end else if (w_dbg_rd_grant) begin
      r_addr      <= r_addr + STEP;
      r_issue_idx <= r_issue_idx + LEN_W'(1);
    end
  end

  // Read-return tracking: who owns next cycle's mem_dout, and which burst word it is.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_owner <= OWN_NONE;
      r_ret_idx  <= '0;
    end else begin
      if (w_cpu_grant && !cpu_we) begin
        r_rd_owner <= OWN_CPU;
      end else if (w_dbg_rd_grant) begin
        r_rd_owner <= OWN_DBG;
      end else begin
        r_rd_owner <= OWN_NONE;
      end
      if (w_dbg_rd_grant) begin
        r_ret_idx <= r_issue_idx;
      end
    end
  end

  // Hold registers keep the last returned word visible after rvalid drops.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_cpu_hold <= '0;
      r_dbg_hold <= '0;
    end else begin
      if (r_rd_owner == OWN_CPU) r_cpu_hold <= mem_dout;
      if (r_rd_owner == OWN_DBG) r_dbg_hold <= mem_dout;
    end
  end

  assign cpu_rvalid = (r_rd_owner == OWN_CPU);
  assign dbg_rvalid = (r_rd_owner == OWN_DBG);
  assign cpu_rdata  = cpu_rvalid ? mem_dout : r_cpu_hold;
  assign dbg_rdata  = dbg_rvalid ? mem_dout : r_dbg_hold;
  assign dbg_idx    = r_ret_idx;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Testbench for dmem_port_arbiter: bench-side 1-cycle memory, a transaction-level
// reference model checked every falling edge, and directed scenarios with literal
// expectations.
module tb_dmem_port_arbiter;
  localparam int LEN_W      = 8;
  localparam int STARVE_MAX = 3;
  localparam int ADDR_STEP  = 1;

  logic             clka = 1'b0;
  logic             rst_n = 1'b0;
  logic             cpu_req = 1'b0;
  logic             cpu_we = 1'b0;
  logic [31:0]      cpu_addr = '0;
  logic [31:0]      cpu_wdata = '0;
  logic             cpu_stall;
  logic             cpu_rvalid;
  logic [31:0]      cpu_rdata;
  logic             dbg_start = 1'b0;
  logic [31:0]      dbg_base = '0;
  logic [LEN_W-1:0] dbg_len = '0;
  logic             dbg_busy;
  logic             dbg_rvalid;
  logic [31:0]      dbg_rdata;
  logic [LEN_W-1:0] dbg_idx;
  logic             dbg_done;
`ifdef DMEM_ARB_DBG_WRITE_EN
  logic             dbg_wr_req = 1'b0;
  logic [31:0]      dbg_wr_addr = '0;
  logic [31:0]      dbg_wr_data = '0;
  logic             dbg_wr_ack;
`endif
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_din;
  logic [31:0]      mem_dout = '0;

  int n_vec = 0;
  int n_err = 0;

  dmem_port_arbiter #(.LEN_W(LEN_W), .STARVE_MAX(STARVE_MAX), .ADDR_STEP(ADDR_STEP)) dut (
    .clka(clka), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_start(dbg_start), .dbg_base(dbg_base), .dbg_len(dbg_len),
    .dbg_busy(dbg_busy), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .dbg_idx(dbg_idx), .dbg_done(dbg_done),
`ifdef DMEM_ARB_DBG_WRITE_EN
    .dbg_wr_req(dbg_wr_req), .dbg_wr_addr(dbg_wr_addr), .dbg_wr_data(dbg_wr_data),
    .dbg_wr_ack(dbg_wr_ack),
`endif
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clka = ~clka;

  // Sparse memory; unwritten locations return an address-derived pattern.
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_5A5A;
  endfunction

  always @(posedge clka) begin
    mem_dout <= rd(mem_addr);
    if (mem_we) mem[mem_addr] = mem_din;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: tracks the burst as (base, len, words issued), plus the one
  // outstanding read return and the starvation count, then predicts every output.
  bit          m_active = 0;
  bit          m_zdone = 0;
  int unsigned m_issued = 0;
  int unsigned m_len = 0;
  logic [31:0] m_base = '0;
  int          m_starve = 0;
  int          m_ret = 0;          // 0 none, 1 cpu, 2 debug
  logic [31:0] m_ret_data = '0;
  int unsigned m_ret_idx = 0;
  logic [31:0] m_cpu_hold = '0;
  logic [31:0] m_dbg_hold = '0;

  always @(negedge clka) begin
    bit rd_pend, wr_pend, dbg_win, cpu_win, e_we, e_done, e_busy;
    logic [31:0] e_addr, e_din, burst_addr;
    if (!rst_n) begin
      chk("rst cpu_stall", 32'(cpu_stall), 0);
      chk("rst mem_we", 32'(mem_we), 0);
      chk("rst mem_addr", mem_addr, 0);
      chk("rst mem_din", mem_din, 0);
      chk("rst cpu_rvalid", 32'(cpu_rvalid), 0);
      chk("rst cpu_rdata", cpu_rdata, 0);
      chk("rst dbg_rvalid", 32'(dbg_rvalid), 0);
      chk("rst dbg_rdata", dbg_rdata, 0);
      chk("rst dbg_busy", 32'(dbg_busy), 0);
      chk("rst dbg_done", 32'(dbg_done), 0);
      m_active = 0; m_zdone = 0; m_issued = 0; m_len = 0; m_starve = 0;
      m_ret = 0; m_cpu_hold = '0; m_dbg_hold = '0;
    end else begin
      rd_pend = m_active && (m_issued < m_len);
`ifdef DMEM_ARB_DBG_WRITE_EN
      wr_pend = dbg_wr_req;
`else
      wr_pend = 0;
`endif
      dbg_win = (rd_pend || wr_pend) && (!cpu_req || m_starve == STARVE_MAX);
      cpu_win = cpu_req && !dbg_win;
      burst_addr = m_base + 32'(m_issued * ADDR_STEP);
      e_we = 0; e_addr = '0; e_din = '0;
      if (dbg_win && rd_pend) e_addr = burst_addr;
`ifdef DMEM_ARB_DBG_WRITE_EN
      else if (dbg_win) begin e_we = 1; e_addr = dbg_wr_addr; e_din = dbg_wr_data; end
`endif
      else if (cpu_win) begin e_we = cpu_we; e_addr = cpu_addr; e_din = cpu_wdata; end
      e_done = m_zdone || (m_ret == 2 && m_ret_idx == m_len - 1);
      e_busy = m_active || m_zdone;

      chk("mem_we", 32'(mem_we), 32'(e_we));
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_din", mem_din, e_din);
      chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !cpu_win));
`ifdef DMEM_ARB_DBG_WRITE_EN
      chk("dbg_wr_ack", 32'(dbg_wr_ack), 32'(dbg_win && !rd_pend));
`endif
      chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_ret == 1));
      chk("cpu_rdata", cpu_rdata, (m_ret == 1) ? m_ret_data : m_cpu_hold);
      chk("dbg_rvalid", 32'(dbg_rvalid), 32'(m_ret == 2));
      chk("dbg_rdata", dbg_rdata, (m_ret == 2) ? m_ret_data : m_dbg_hold);
      if (m_ret == 2) chk("dbg_idx", 32'(dbg_idx), m_ret_idx);
      chk("dbg_done", 32'(dbg_done), 32'(e_done));
      chk("dbg_busy", 32'(dbg_busy), 32'(e_busy));

      if (m_ret == 1) m_cpu_hold = m_ret_data;
      if (m_ret == 2) m_dbg_hold = m_ret_data;
      if (e_done) begin m_active = 0; m_zdone = 0; end
      if (!(rd_pend || wr_pend) || dbg_win) m_starve = 0;
      else if (cpu_win) m_starve++;
      if (cpu_win && !cpu_we) begin
        m_ret = 1; m_ret_data = rd(cpu_addr);
      end else if (dbg_win && rd_pend) begin
        m_ret = 2; m_ret_data = rd(burst_addr); m_ret_idx = m_issued; m_issued++;
      end else begin
        m_ret = 0;
      end
      if (!e_busy && dbg_start) begin
        if (dbg_len == '0) m_zdone = 1;
        else begin m_active = 1; m_issued = 0; m_len = dbg_len; m_base = dbg_base; end
      end
    end
  end

  task automatic cyc();
    @(posedge clka);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic start(input logic [31:0] base, input int len);
    dbg_start = 1'b1; dbg_base = base; dbg_len = LEN_W'(len);
  endtask

  initial begin
    logic [31:0] wrap_exp [4];
    int stalls;
    wrap_exp = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};

    // Reset state
    cyc(); cyc();
    chk("reset busy", 32'(dbg_busy), 0);
    rst_n = 1'b1;
    cyc();

    // 1: CPU write then read back
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'hDEAD_BEEF;
    settle(); chk("t1 wr stall", 32'(cpu_stall), 0); chk("t1 wr we", 32'(mem_we), 1);
    cyc();
    cpu_we = 0;
    settle(); chk("t1 rd stall", 32'(cpu_stall), 0);
    cyc();
    cpu_req = 0;
    settle(); chk("t1 rvalid", 32'(cpu_rvalid), 1); chk("t1 rdata", cpu_rdata, 32'hDEAD_BEEF);
    cyc(); cyc();

    // 2: burst base=16 len=4 with CPU idle
    start(32'd16, 4);
    cyc();
    dbg_start = 0; dbg_base = 32'h999; dbg_len = 8'd7;
    for (int c = 0; c < 6; c++) begin
      settle();
      if (c < 4) chk("t2 addr", mem_addr, 32'(16 + c));
      chk("t2 rvalid", 32'(dbg_rvalid), 32'(c >= 1 && c <= 4));
      if (c >= 1 && c <= 4) chk("t2 idx", 32'(dbg_idx), 32'(c - 1));
      chk("t2 done", 32'(dbg_done), 32'(c == 4));
      chk("t2 busy", 32'(dbg_busy), 32'(c <= 4));
      cyc();
    end

    // 3: CPU hammering reads during a len=3 burst
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
    start(32'h40, 3);
    settle(); chk("t3 start stall", 32'(cpu_stall), 0);
    cyc();
    dbg_start = 0;
    stalls = 0;
    for (int c = 0; c < 12; c++) begin
      settle();
      chk("t3 stall", 32'(cpu_stall), 32'(c % 4 == 3));
      if (cpu_stall) stalls++;
      cyc();
    end
    settle(); chk("t3 done", 32'(dbg_done), 1); chk("t3 stalls", 32'(stalls), 3);
    cpu_req = 0;
    cyc(); cyc();

    // 4: zero-length burst
    start(32'h80, 0);
    cyc();
    dbg_start = 0;
    settle(); chk("t4 done", 32'(dbg_done), 1); chk("t4 we", 32'(mem_we), 0);
    chk("t4 addr", mem_addr, 0); chk("t4 rvalid", 32'(dbg_rvalid), 0);
    cyc();
    settle(); chk("t4 done gone", 32'(dbg_done), 0); chk("t4 busy", 32'(dbg_busy), 0);
    cyc();

    // 5: reset mid-burst, then a fresh len=1 burst
    start(32'h200, 8);
    cyc();
    dbg_start = 0;
    cyc(); cyc();
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h44; cpu_wdata = 32'h1111_2222;
    rst_n = 0;
    #1;
    chk("t5 busy", 32'(dbg_busy), 0); chk("t5 rvalid", 32'(dbg_rvalid), 0);
    chk("t5 done", 32'(dbg_done), 0); chk("t5 we", 32'(mem_we), 0);
    chk("t5 stall", 32'(cpu_stall), 0); chk("t5 addr", mem_addr, 0);
    cyc(); cyc();
    cpu_req = 0; cpu_we = 0;
    rst_n = 1;
    cyc();
    start(32'h300, 1);
    cyc();
    dbg_start = 0;
    settle(); chk("t5 new addr", mem_addr, 32'h300);
    cyc();
    settle(); chk("t5 new rvalid", 32'(dbg_rvalid), 1); chk("t5 new done", 32'(dbg_done), 1);
    chk("t5 new data", dbg_rdata, 32'h300 ^ 32'h5A5A_5A5A);
    cyc();

    // 6: address wrap
    start(32'hFFFF_FFFE, 4);
    cyc();
    dbg_start = 0;
    for (int c = 0; c < 4; c++) begin
      settle(); chk("t6 addr", mem_addr, wrap_exp[c]);
      cyc();
    end
    cyc(); cyc();

`ifdef DMEM_ARB_DBG_WRITE_EN
    dbg_wr_req = 1; dbg_wr_addr = 32'h5; dbg_wr_data = 32'h1234;
    settle(); chk("t6 wr ack", 32'(dbg_wr_ack), 1); chk("t6 wr we", 32'(mem_we), 1);
    cyc();
    dbg_wr_req = 0;
    start(32'h3, 4);
    cyc();
    dbg_start = 0;
    for (int c = 0; c < 6; c++) begin
      settle();
      if (c == 3) chk("t6 wr readback", dbg_rdata, 32'h1234);
      cyc();
    end
`endif

    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
